// File: rtl/irq_timer_pkg.sv
// Shared definitions for the machine-level interrupt source.
//   - Word addresses of the software-visible registers.
//   - Bit positions inside the CTRL register.
//   - Bit positions of MTIP/MEIP inside the mip-format interrupt vector.
package irq_timer_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_MTIME    = 3'd2;
  localparam logic [2:0] ADDR_MTIMECMP = 3'd3;
  localparam logic [2:0] ADDR_EXT_EN   = 3'd4;
  localparam logic [2:0] ADDR_EXT_MODE = 3'd5;
  localparam logic [2:0] ADDR_PEND     = 3'd6;
  localparam logic [2:0] ADDR_STATUS   = 3'd7;

  localparam int CTRL_TIMER_EN = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_TIE      = 2;
  localparam int CTRL_W        = 3;

  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;

endpackage

// File: rtl/irq_sync_edge.sv
// One external interrupt channel.
//   A 2-flop synchroniser brings the asynchronous request into the clk
//   domain; a history flop provides rising-edge detection.
//   Edge mode: a rising edge sets a sticky pending bit, cleared by W1C.
//   Level mode: pending follows the synchronised level, W1C is ignored.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   ext_irq     : raw asynchronous request line
//   edge_mode   : 1 = edge-triggered, 0 = level-sensitive
//   clr         : software write-1-to-clear for this line
//   sync_level  : synchronised request level
//   pend        : pending state presented to the register file
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ext_irq,
  input  logic edge_mode,
  input  logic clr,
  output logic sync_level,
  output logic pend
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pend_q;
  logic rise;

  assign rise = sync2_q & ~prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its neighbour; this is what makes the chain a shift register.
      sync1_q <= ext_irq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // The sticky bit is kept clear in level mode so that switching a line
      // to edge mode starts from a clean state. A new edge wins over W1C.
      if (!edge_mode) begin
        pend_q <= 1'b0;
      end else if (rise) begin
        pend_q <= 1'b1;
      end else if (clr) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign sync_level = sync2_q;
  assign pend       = edge_mode ? pend_q : sync2_q;

endmodule

// File: rtl/irq_timer_unit.sv
// Machine-level interrupt source for the RISC-V core.
//   Prescaled programmable timer (one-shot or periodic compare) plus N_EXT
//   synchronised external lines, merged into a mip-format interrupt vector.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   ext_irq      : asynchronous external request lines
//   reg_wr/rd    : register write / read strobes
//   reg_addr     : word address (see irq_timer_pkg)
//   reg_wdata    : write data
//   reg_rdata    : registered read data, valid with reg_rvalid
//   reg_rvalid   : one-cycle pulse the cycle after reg_rd
//   interrupt    : bit 7 MTIP, bit 11 MEIP, all other bits zero
module irq_timer_unit
  import irq_timer_pkg::*;
#(
  parameter int TIMER_W    = 32,
  parameter int N_EXT      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EXT-1:0] ext_irq,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [2:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_rvalid,
  output logic [31:0]      interrupt
);

  // Configuration registers
  logic [CTRL_W-1:0]     ctrl_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [TIMER_W-1:0]    mtimecmp_q;
  logic [N_EXT-1:0]      ext_en_q;
  logic [N_EXT-1:0]      ext_mode_q;

  // Timer state
  logic [PRESCALE_W-1:0] pcnt_q;
  logic [TIMER_W-1:0]    mtime_q;
  logic                  tpend_q;

  // Write decode
  logic wr_ctrl, wr_prescale, wr_mtime, wr_mtimecmp;
  logic wr_ext_en, wr_ext_mode, wr_pend;

  assign wr_ctrl     = reg_wr && (reg_addr == ADDR_CTRL);
  assign wr_prescale = reg_wr && (reg_addr == ADDR_PRESCALE);
  assign wr_mtime    = reg_wr && (reg_addr == ADDR_MTIME);
  assign wr_mtimecmp = reg_wr && (reg_addr == ADDR_MTIMECMP);
  assign wr_ext_en   = reg_wr && (reg_addr == ADDR_EXT_EN);
  assign wr_ext_mode = reg_wr && (reg_addr == ADDR_EXT_MODE);
  assign wr_pend     = reg_wr && (reg_addr == ADDR_PEND);

  // Only the low bits of the write bus are architecturally meaningful.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;

  logic timer_en, periodic, tie;
  assign timer_en = ctrl_q[CTRL_TIMER_EN];
  assign periodic = ctrl_q[CTRL_PERIODIC];
  assign tie      = ctrl_q[CTRL_TIE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      mtimecmp_q <= '1;
      ext_en_q   <= '0;
      ext_mode_q <= '0;
    end else begin
      if (wr_ctrl)     ctrl_q     <= reg_wdata[CTRL_W-1:0];
      if (wr_prescale) prescale_q <= reg_wdata[PRESCALE_W-1:0];
      if (wr_mtimecmp) mtimecmp_q <= reg_wdata[TIMER_W-1:0];
      if (wr_ext_en)   ext_en_q   <= reg_wdata[N_EXT-1:0];
      if (wr_ext_mode) ext_mode_q <= reg_wdata[N_EXT-1:0];
    end
  end

  // Prescaler tick and periodic wrap condition
  logic tick;
  logic wrap;
  logic w1c_timer;

  assign tick      = timer_en && (pcnt_q == prescale_q);
  assign wrap      = tick && periodic && (mtime_q == mtimecmp_q);
  assign w1c_timer = wr_pend && reg_wdata[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q  <= '0;
      mtime_q <= '0;
      tpend_q <= 1'b0;
    end else begin
      // Restarting the prescaler on a PRESCALE write keeps pcnt from being
      // stranded above a newly lowered terminal count.
      if (wr_prescale) begin
        pcnt_q <= '0;
      end else if (timer_en) begin
        pcnt_q <= tick ? '0 : pcnt_q + PRESCALE_W'(1);
      end

      // Software write to MTIME wins over the tick increment.
      if (wr_mtime) begin
        mtime_q <= reg_wdata[TIMER_W-1:0];
      end else if (tick) begin
        mtime_q <= wrap ? '0 : mtime_q + TIMER_W'(1);
      end

      // Sticky periodic pending; a wrap wins over a simultaneous W1C.
      if (wrap) begin
        tpend_q <= 1'b1;
      end else if (w1c_timer) begin
        tpend_q <= 1'b0;
      end
    end
  end

  // In one-shot mode pending is a pure compare level, so only rewriting
  // MTIME or MTIMECMP can drop it.
  logic timer_pend;
  assign timer_pend = periodic ? tpend_q : (mtime_q >= mtimecmp_q);

  // External channels
  logic [N_EXT-1:0] ext_sync;
  logic [N_EXT-1:0] ext_pend;

  for (genvar i = 0; i < N_EXT; i++) begin : g_ext
    irq_sync_edge u_chan (
      .clk        (clk),
      .reset      (reset),
      .ext_irq    (ext_irq[i]),
      .edge_mode  (ext_mode_q[i]),
      .clr        (wr_pend && reg_wdata[i+1]),
      .sync_level (ext_sync[i]),
      .pend       (ext_pend[i])
    );
  end

  // Read mux: reflects pre-edge state, so a same-cycle write is not seen.
  logic [31:0] rd_mux;

  always_comb begin
    // NOTE: default assignment first so no path through the case can leave
    // rd_mux unassigned and infer a latch.
    rd_mux = '0;
    case (reg_addr)
      ADDR_CTRL:     rd_mux[CTRL_W-1:0]     = ctrl_q;
      ADDR_PRESCALE: rd_mux[PRESCALE_W-1:0] = prescale_q;
      ADDR_MTIME:    rd_mux[TIMER_W-1:0]    = mtime_q;
      ADDR_MTIMECMP: rd_mux[TIMER_W-1:0]    = mtimecmp_q;
      ADDR_EXT_EN:   rd_mux[N_EXT-1:0]      = ext_en_q;
      ADDR_EXT_MODE: rd_mux[N_EXT-1:0]      = ext_mode_q;
      ADDR_PEND:     rd_mux[N_EXT:0]        = {ext_pend, timer_pend};
      ADDR_STATUS:   rd_mux[N_EXT-1:0]      = ext_sync;
      default:       rd_mux                 = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_rd;
      if (reg_rd) reg_rdata <= rd_mux;
    end
  end

  // Interrupt vector: combinational from registered state only.
  always_comb begin
    interrupt           = '0;
    interrupt[MTIP_BIT] = tie && timer_pend;
    interrupt[MEIP_BIT] = |(ext_pend & ext_en_q);
  end

endmodule

// File: tb/tb_irq_timer_unit.sv
module tb_irq_timer_unit;
  import irq_timer_pkg::*;

  localparam int N_EXT = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_EXT-1:0] ext_irq = '0;
  logic             reg_wr = 1'b0;
  logic             reg_rd = 1'b0;
  logic [2:0]       reg_addr = '0;
  logic [31:0]      reg_wdata = '0;
  logic [31:0]      reg_rdata;
  logic             reg_rvalid;
  logic [31:0]      interrupt;

  irq_timer_unit #(.TIMER_W(32), .N_EXT(N_EXT), .PRESCALE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ext_irq    (ext_irq),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .interrupt  (interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    int          due;
    logic [2:0]  addr;
  } rd_exp_t;

  rd_exp_t rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-response monitor: pops the scoreboard whenever reg_rvalid is seen.
  always @(negedge clk) begin
    if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL rd_timeout addr %0d: no reg_rvalid by cycle %0d", rd_q[0].addr, rd_q[0].due);
      void'(rd_q.pop_front());
    end
    if (reg_rvalid) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: reg_rvalid with data 0x%08h, expected no response", reg_rdata);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check($sformatf("rd_data_addr%0d", e.addr), reg_rdata, e.data);
        check($sformatf("rd_latency_addr%0d", e.addr), cyc, e.due);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    step(1);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    rd_q.push_back('{data: exp, due: cyc + 1, addr: a});
    reg_rd = 1'b1; reg_addr = a;
    step(1);
    reg_rd = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp_old);
    rd_q.push_back('{data: exp_old, due: cyc + 1, addr: a});
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    step(1);
    reg_rd = 1'b0; reg_wr = 1'b0;
  endtask

  // Counts edges until MTIP is seen, bounded.
  task automatic wait_mtip(output int n);
    n = 0;
    while (!interrupt[MTIP_BIT] && n < 200) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;

    // Reset state
    #23;
    check("irq_in_reset", interrupt, 32'h0);
    check("rvalid_in_reset", 32'(reg_rvalid), 32'h0);
    check("rdata_in_reset", reg_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1);

    rd(ADDR_CTRL,     32'h0);
    rd(ADDR_PRESCALE, 32'h0);
    rd(ADDR_MTIME,    32'h0);
    rd(ADDR_MTIMECMP, 32'hFFFF_FFFF);
    rd(ADDR_EXT_EN,   32'h0);
    rd(ADDR_EXT_MODE, 32'h0);
    rd(ADDR_PEND,     32'h0);
    rd(ADDR_STATUS,   32'h0);

    // Same-cycle read/write returns old value; unused bits read zero
    rdwr(ADDR_EXT_EN, 32'hFFFF_FFFF, 32'h0);
    rd(ADDR_EXT_EN, 32'h0000_000F);
    wr(ADDR_EXT_EN, 32'h0);
    wr(ADDR_MTIME, 32'h1234_5678);
    rd(ADDR_MTIME, 32'h1234_5678);

    // Periodic: PRESCALE=3, MTIMECMP=4 -> period 20 cycles
    wr(ADDR_PRESCALE, 32'd3);
    wr(ADDR_MTIMECMP, 32'd4);
    wr(ADDR_MTIME, 32'd0);
    wr(ADDR_CTRL, 32'b111);
    wait_mtip(n);
    check("periodic_first_rise", n, 20);
    c0 = cyc;
    wr(ADDR_PEND, 32'h1);
    check("periodic_w1c_clears", interrupt, 32'h0);
    wait_mtip(n);
    check("periodic_second_rise", cyc - c0, 20);
    step(25);
    check("periodic_sticky", interrupt, 32'h0000_0080);
    rd(ADDR_CTRL, 32'h7);
    wr(ADDR_CTRL, 32'b110);
    check("periodic_stop_keeps_pend", interrupt, 32'h0000_0080);
    rd(ADDR_PEND, 32'h1);
    wr(ADDR_PEND, 32'h1);
    check("periodic_w1c_after_stop", interrupt, 32'h0);
    wr(ADDR_CTRL, 32'h0);

    // One-shot: MTIMECMP=10, PRESCALE=0
    wr(ADDR_PRESCALE, 32'd0);
    wr(ADDR_MTIMECMP, 32'd10);
    wr(ADDR_MTIME, 32'd0);
    wr(ADDR_CTRL, 32'b101);
    wait_mtip(n);
    check("oneshot_rise", n, 10);
    wr(ADDR_PEND, 32'h1);
    check("oneshot_w1c_no_effect", interrupt, 32'h0000_0080);
    wr(ADDR_MTIMECMP, 32'd100);
    check("oneshot_cmp_rewrite", interrupt, 32'h0);
    wr(ADDR_CTRL, 32'h0);

    // Edge mode on line 0
    wr(ADDR_EXT_MODE, 32'h1);
    wr(ADDR_EXT_EN, 32'h1);
    ext_irq[0] = 1'b1;
    step(1);
    ext_irq[0] = 1'b0;
    step(1);
    check("edge_meip_after_edge1", interrupt, 32'h0);
    step(1);
    check("edge_meip_after_edge2", interrupt, 32'h0000_0800);
    rd(ADDR_PEND, 32'h2);
    wr(ADDR_PEND, 32'h2);
    check("edge_w1c_clears", interrupt, 32'h0);
    rd(ADDR_PEND, 32'h0);
    ext_irq[0] = 1'b1;
    step(1);
    ext_irq[0] = 1'b0;
    step(1);
    wr(ADDR_PEND, 32'h2);
    check("edge_set_beats_clear", interrupt, 32'h0000_0800);
    rd(ADDR_PEND, 32'h2);
    wr(ADDR_PEND, 32'h2);
    check("edge_final_clear", interrupt, 32'h0);

    // Level mode on line 2
    wr(ADDR_EXT_MODE, 32'h0);
    wr(ADDR_EXT_EN, 32'h0);
    ext_irq[2] = 1'b1;
    step(3);
    rd(ADDR_PEND, 32'h8);
    rd(ADDR_STATUS, 32'h4);
    check("level_disabled_masked", interrupt, 32'h0);
    wr(ADDR_EXT_EN, 32'h4);
    check("level_enabled", interrupt, 32'h0000_0800);
    wr(ADDR_PEND, 32'h8);
    rd(ADDR_PEND, 32'h8);
    ext_irq[2] = 1'b0;
    step(1);
    check("level_fall_edge1", interrupt, 32'h0000_0800);
    step(1);
    check("level_fall_edge2", interrupt, 32'h0);
    ext_irq[2] = 1'b1;
    step(1);
    check("level_rise_edge0", interrupt, 32'h0);
    step(1);
    check("level_rise_edge1", interrupt, 32'h0000_0800);

    // Async reset mid-count
    wr(ADDR_PRESCALE, 32'd0);
    wr(ADDR_MTIMECMP, 32'd1000);
    wr(ADDR_CTRL, 32'b111);
    step(5);
    check("pre_reset_irq", interrupt, 32'h0000_0800);
    #2;
    reset = 1'b1;
    #1;
    check("reset_irq_immediate", interrupt, 32'h0);
    check("reset_rvalid_immediate", 32'(reg_rvalid), 32'h0);
    ext_irq = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(ADDR_MTIME, 32'h0);
    rd(ADDR_CTRL, 32'h0);
    rd(ADDR_MTIMECMP, 32'hFFFF_FFFF);
    rd(ADDR_EXT_EN, 32'h0);

    // First tick PRESCALE+1 cycles after enable
    wr(ADDR_PRESCALE, 32'd2);
    wr(ADDR_MTIMECMP, 32'd1);
    wr(ADDR_CTRL, 32'b101);
    wait_mtip(n);
    check("first_tick_latency", n, 3);

    step(3);
    check("rd_queue_drained", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
